// File: rtl/dsp_branch_if.sv
// dsp_branch_if: decode-to-branch-unit request and fetch redirect bundle
interface dsp_branch_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              br_valid;
    logic [2:0]        br_op;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] br_pc;
    logic [CNT_W-1:0]  br_count;
    logic              cond_zero;
    logic              jump_flag;
    logic [ADDR_W-1:0] jump_addr;
    logic              flush;

    modport master (
        output br_valid, br_op, br_target, br_pc, br_count, cond_zero,
        input  jump_flag, jump_addr, flush
    );

    modport slave (
        input  br_valid, br_op, br_target, br_pc, br_count, cond_zero,
        output jump_flag, jump_addr, flush
    );
endinterface

// File: rtl/dsp_branch.sv
// dsp_branch: branch unit with jumps, call/return stack and a single hardware loop
module dsp_branch #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    dsp_branch_if.slave                    br,
    output logic                           loop_active,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           ovf_err,
    output logic                           unf_err
);
    localparam int SW = $clog2(STACK_DEPTH) + 1;
    localparam int DW = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_JMP     = 3'b001;
    localparam logic [2:0] OP_JZ      = 3'b010;
    localparam logic [2:0] OP_JNZ     = 3'b011;
    localparam logic [2:0] OP_CALL    = 3'b100;
    localparam logic [2:0] OP_RET     = 3'b101;
    localparam logic [2:0] OP_LOOP    = 3'b110;
    localparam logic [2:0] OP_ENDLOOP = 3'b111;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic              jump_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  counter;
    logic [ADDR_W-1:0] loop_start;

    logic              take, full, empty;
    logic              do_jmp, do_push, do_pop, ovf_set, unf_set;
    logic              loop_load, end_jump, end_exit, jump_now;
    logic [ADDR_W-1:0] ret_addr, next_addr;
    logic [DW-1:0]     push_idx, top_idx;

    // decode the branch request; instructions in the redirect shadow are wrong-path and dropped
    always_comb begin
        take      = br.br_valid && !jump_q;
        full      = stack_depth == SW'(STACK_DEPTH);
        empty     = stack_depth == '0;
        ret_addr  = br.br_pc + ADDR_W'(1);
        push_idx  = DW'(stack_depth);
        top_idx   = DW'(stack_depth - SW'(1));
        do_jmp    = take && ((br.br_op == OP_JMP) ||
                             (br.br_op == OP_JZ  &&  br.cond_zero) ||
                             (br.br_op == OP_JNZ && !br.cond_zero));
        do_push   = take && br.br_op == OP_CALL && !full;
        ovf_set   = take && br.br_op == OP_CALL && full;
        do_pop    = take && br.br_op == OP_RET && !empty;
        unf_set   = take && br.br_op == OP_RET && empty;
        loop_load = take && br.br_op == OP_LOOP;
        end_jump  = take && br.br_op == OP_ENDLOOP && loop_active && counter != '0;
        end_exit  = take && br.br_op == OP_ENDLOOP && loop_active && counter == '0;
        jump_now  = do_jmp || do_push || do_pop || end_jump;
        next_addr = do_pop ? stack[top_idx] : end_jump ? loop_start : br.br_target;
    end

    // redirect pulse, stack pointer, sticky errors and loop state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_q      <= 1'b0;
            addr_q      <= '0;
            loop_active <= 1'b0;
            counter     <= '0;
            loop_start  <= '0;
            stack_depth <= '0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            jump_q  <= jump_now;
            ovf_err <= ovf_err | ovf_set;
            unf_err <= unf_err | unf_set;
            if (jump_now)
                addr_q <= next_addr;
            if (do_push)
                stack_depth <= stack_depth + SW'(1);
            else if (do_pop)
                stack_depth <= stack_depth - SW'(1);
            if (loop_load) begin
                counter     <= br.br_count;
                loop_start  <= ret_addr;
                loop_active <= 1'b1;
            end else if (end_jump) begin
                counter <= counter - CNT_W'(1);
            end else if (end_exit) begin
                loop_active <= 1'b0;
            end
        end
    end

    // return-address storage; contents are meaningless above stack_depth so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push)
            stack[push_idx] <= ret_addr;
    end

    assign br.jump_flag = jump_q;
    assign br.flush     = jump_q;
    assign br.jump_addr = addr_q;
endmodule

// File: tb/tb_dsp_branch.sv
// tb_dsp_branch: directed scoreboard bench for the branch unit
module tb_dsp_branch;
    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                           CALL = 3'd4, RET = 3'd5, LOOP = 3'd6, ENDL = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loop_active, ovf_err, unf_err;
    logic [2:0] stack_depth;
    int         checks = 0;
    int         errors = 0;
    logic [16:0] exp_q [$];

    dsp_branch_if #(.ADDR_W(16), .CNT_W(16)) bi ();

    dsp_branch #(.ADDR_W(16), .STACK_DEPTH(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br          (bi),
        .loop_active (loop_active),
        .stack_depth (stack_depth),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [15:0] tgt,
                        input logic [15:0] pc, input logic [15:0] cnt, input logic cz,
                        input logic ej, input logic [15:0] ea);
        logic [16:0] e;
        @(negedge clk);
        bi.br_valid  = v;
        bi.br_op     = op;
        bi.br_target = tgt;
        bi.br_pc     = pc;
        bi.br_count  = cnt;
        bi.cond_zero = cz;
        exp_q.push_back({ej, ea});
        @(posedge clk);
        #1;
        bi.br_valid = 1'b0;
        e = exp_q.pop_front();
        chk("jump_flag", 32'(bi.jump_flag), 32'(e[16]));
        chk("flush", 32'(bi.flush), 32'(e[16]));
        if (e[16])
            chk("jump_addr", 32'(bi.jump_addr), 32'(e[15:0]));
    endtask

    task automatic idle();
        step(1'b0, JMP, 16'hDEAD, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic chk_reset_state();
        chk("rst_jump_flag", 32'(bi.jump_flag), 0);
        chk("rst_jump_addr", 32'(bi.jump_addr), 0);
        chk("rst_flush", 32'(bi.flush), 0);
        chk("rst_loop_active", 32'(loop_active), 0);
        chk("rst_depth", 32'(stack_depth), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_unf", 32'(unf_err), 0);
    endtask

    initial begin
        bi.br_valid = 1'b0; bi.br_op = NOP; bi.br_target = '0;
        bi.br_pc = '0; bi.br_count = '0; bi.cond_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, JMP, 16'h0040, 16'h0005, 16'h0, 1'b0, 1'b1, 16'h0040);
        step(1'b1, JMP, 16'h0099, 16'h0006, 16'h0, 1'b0, 1'b0, 16'h0);
        idle();

        step(1'b1, JZ, 16'h0100, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b1, JZ, 16'h0100, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0100);
        idle();
        step(1'b1, JNZ, 16'h0200, 16'h0011, 16'h0, 1'b1, 1'b0, 16'h0);
        step(1'b1, JNZ, 16'h0200, 16'h0011, 16'h0, 1'b0, 1'b1, 16'h0200);
        idle();

        step(1'b1, CALL, 16'h0010, 16'hFFFF, 16'h0, 1'b0, 1'b1, 16'h0010);
        idle();
        chk("depth_after_call", 32'(stack_depth), 1);
        step(1'b1, RET, 16'h0, 16'h0012, 16'h0, 1'b0, 1'b1, 16'h0000);
        idle();
        chk("depth_after_ret", 32'(stack_depth), 0);
        chk("unf_before", 32'(unf_err), 0);
        step(1'b1, RET, 16'h0, 16'h0013, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("unf_set", 32'(unf_err), 1);
        idle();
        step(1'b1, NOP, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("unf_sticky", 32'(unf_err), 1);
        chk("depth_after_unf", 32'(stack_depth), 0);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, CALL, 16'(16'h0200 + i), 16'(16'h0100 + 16 * i), 16'h0, 1'b0,
                 1'b1, 16'(16'h0200 + i));
            idle();
            chk("depth_push", 32'(stack_depth), 32'(i + 1));
        end
        step(1'b1, CALL, 16'h0300, 16'h0180, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("ovf_set", 32'(ovf_err), 1);
        chk("depth_full", 32'(stack_depth), 4);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, RET, 16'h0, 16'h0400, 16'h0, 1'b0, 1'b1, 16'(16'h0101 + 16 * i));
            idle();
            chk("depth_pop", 32'(stack_depth), 32'(i));
        end
        chk("ovf_sticky", 32'(ovf_err), 1);

        step(1'b1, LOOP, 16'h0, 16'h0020, 16'd2, 1'b0, 1'b0, 16'h0);
        chk("loop_armed", 32'(loop_active), 1);
        step(1'b1, ENDL, 16'h0, 16'h0030, 16'h0, 1'b0, 1'b1, 16'h0021);
        idle();
        step(1'b1, ENDL, 16'h0, 16'h0030, 16'h0, 1'b0, 1'b1, 16'h0021);
        idle();
        chk("loop_still_armed", 32'(loop_active), 1);
        step(1'b1, ENDL, 16'h0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("loop_done", 32'(loop_active), 0);
        step(1'b1, ENDL, 16'h0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b1, LOOP, 16'h0, 16'h0050, 16'd0, 1'b0, 1'b0, 16'h0);
        step(1'b1, ENDL, 16'h0, 16'h0051, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("loop_zero_count", 32'(loop_active), 0);

        step(1'b1, JMP, 16'h0040, 16'h0060, 16'h0, 1'b0, 1'b1, 16'h0040);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, JMP, 16'h0077, 16'h0070, 16'h0, 1'b0, 1'b1, 16'h0077);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_branch.md
DSP_BRANCH -- requirements
Module: dsp_branch

Parameters
REQ-001 ADDR_W, 16, program address width; equals the fetch-stage PC width.
REQ-002 STACK_DEPTH, 4, number of return-address stack entries.
REQ-003 CNT_W, 16, loop counter width.

Interface
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 br_valid  input  1  decode presents a branch-class instruction this cycle.
REQ-007 br_op  input  3  000 NOP, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 LOOP, 111 ENDLOOP.
REQ-008 br_target  input  ADDR_W  absolute target for JMP/JZ/JNZ/CALL.
REQ-009 br_pc  input  ADDR_W  address of the branch instruction.
REQ-010 br_count  input  CNT_W  loop count operand for LOOP.
REQ-011 cond_zero  input  1  ALU zero flag, valid with br_valid.
REQ-012 jump_flag  output  1  registered redirect to fetch; one-cycle pulse.
REQ-013 jump_addr  output  ADDR_W  registered redirect address, valid while jump_flag=1.
REQ-014 flush  output  1  registered; equals jump_flag; decode discards its current instruction.
REQ-015 loop_active  output  1  a LOOP is armed.
REQ-016 stack_depth  output  clog2(STACK_DEPTH)+1  current return-stack occupancy.
REQ-017 ovf_err, unf_err  output  1 each  sticky stack overflow / underflow flags.

Function
REQ-018 br_valid is sampled at edge N; the resulting jump_flag/jump_addr/flush are driven during cycle N+1 only (latency 1, pulse width 1).
REQ-019 Shadow: while jump_flag=1, br_valid is ignored with no state change (wrong-path instruction).
REQ-020 JMP: jump to br_target.
REQ-021 JZ: jump to br_target iff cond_zero=1; JNZ: iff cond_zero=0; otherwise no jump and no state change.
REQ-022 CALL: push ret=(br_pc+1) mod 2^ADDR_W, jump to br_target; with stack_depth=STACK_DEPTH: no push, no jump, set ovf_err.
REQ-023 RET: pop top entry and jump to it; with stack_depth=0: no jump, set unf_err.
REQ-024 LOOP: load counter=br_count, loop_start=(br_pc+1) mod 2^ADDR_W, set loop_active; no jump; LOOP while active overwrites (no nesting).
REQ-025 ENDLOOP, loop_active=1: counter!=0 -> counter-1, jump to loop_start; counter=0 -> clear loop_active, no jump (body runs br_count+1 times).
REQ-026 ENDLOOP with loop_active=0 and NOP: no effect.
REQ-027 Stack is LIFO; push/pop change stack_depth by exactly 1; only one stack operation per cycle.
REQ-028 ovf_err/unf_err, once set, hold until reset.
REQ-029 br_op and operands are don't-care when br_valid=0.

Reset
REQ-030 rst_n=0 asynchronously forces jump_flag=0, jump_addr=0, flush=0, loop_active=0, counter=0, loop_start=0, stack_depth=0, ovf_err=0, unf_err=0; stack contents need not be cleared.
REQ-031 Reset asserted during a jump pulse kills the pulse immediately; the first br_valid after rst_n rises is processed normally.

Verification
REQ-032 JMP br_target=0x0040 at edge N -> jump_flag=1, jump_addr=0x0040, flush=1 in cycle N+1 only; br_valid in N+1 produces nothing.
REQ-033 JZ target 0x0100 with cond_zero=0 -> no jump; repeated with cond_zero=1 -> jump to 0x0100.
REQ-034 CALL br_pc=0xFFFF target 0x0010 -> jump to 0x0010, depth=1; RET -> jump to 0x0000, depth=0; second RET -> no jump, unf_err=1 and stays 1.
REQ-035 Five CALLs (depth 4) -> fifth gives no jump, ovf_err=1, depth=4; four RETs return addresses in reverse push order.
REQ-036 LOOP br_pc=0x0020 br_count=2, then ENDLOOP three times -> jumps to 0x0021, 0x0021, then fall through, loop_active=0.
REQ-037 rst_n low mid-pulse after JMP -> jump_flag=0 same cycle, all outputs at reset values.
